data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//   Single-port data memory behind a valid/ready request channel and a
//   valid/ready response channel. A request is accepted only in IDLE, it waits
//   LATENCY cycles, and then commits: a store updates the addressed byte lanes
//   and a load captures its extended data into an output register. The
//   response is held until the requester takes it.
// ----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int LATENCY     = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iReqValid,
   output logic        oReqReady,
   input  logic        iReqWrite,
   input  logic [1:0]  iReqSize,
   input  logic        iReqUnsigned,
   input  logic [31:0] iReqAddr,
   input  logic [31:0] iReqWData,
   output logic        oRespValid,
   input  logic        iRespReady,
   output logic [31:0] oRespRData,
   output logic        oRespErr
);

   // Word index width into the storage array.
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   // Counter value loaded on accept; a count of 0 means "commit this cycle".
   localparam logic [3:0]  LAT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
   localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // Everything about a request that must survive past the accept cycle.
   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   req_t        r_req;
   req_t        w_req_in;
   req_t        w_req_cur;
   logic        w_accept;
   logic        w_commit;
   logic        w_err;
   logic [AW-1:0] w_idx;
   logic [3:0]  w_be;
   logic [31:0] w_wlanes;
   logic [31:0] w_rword;
   logic [31:0] w_shift;
   logic [31:0] w_load;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   assign w_accept = iReqValid && (r_state == S_IDLE);

   assign w_req_in = '{
      write: iReqWrite,
      size:  iReqSize,
      uns:   iReqUnsigned,
      addr:  iReqAddr,
      wdata: iReqWData
   };

   // With LATENCY = 0 the commit happens on the accept edge itself, so the
   // live request inputs are used in IDLE; otherwise the latched copy is used.
   assign w_req_cur = (r_state == S_IDLE) ? w_req_in : r_req;

   // Decode error, lane enables and lane-replicated store data for the access.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_err    = 1'b0;
      w_be     = 4'b0000;
      w_wlanes = w_req_cur.wdata;
      w_idx    = w_req_cur.addr[AW+1:2];

      if ({2'b00, w_req_cur.addr[31:2]} >= DEPTH_LIM) begin
         w_err = 1'b1;
      end

      case (w_req_cur.size)
         SZ_BYTE: begin
            w_be     = 4'b0001 << w_req_cur.addr[1:0];
            w_wlanes = {4{w_req_cur.wdata[7:0]}};
         end
         SZ_HALF: begin
            w_be     = w_req_cur.addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{w_req_cur.wdata[15:0]}};
            if (w_req_cur.addr[0]) begin
               w_err = 1'b1;
            end
         end
         SZ_WORD: begin
            w_be = 4'b1111;
            if (w_req_cur.addr[1:0] != 2'b00) begin
               w_err = 1'b1;
            end
         end
         default: begin
            w_err = 1'b1;
         end
      endcase
   end

   // Select the addressed lanes of the stored word, right-justify and extend.
   always_comb begin
      w_rword = r_mem[w_idx];
      w_shift = w_rword >> {w_req_cur.addr[1:0], 3'b000};
      case (w_req_cur.size)
         SZ_BYTE: w_load = w_req_cur.uns ? {24'd0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
         SZ_HALF: w_load = w_req_cur.uns ? {16'd0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
         default: w_load = w_shift;
      endcase
   end

   // Next-state and counter logic; also flags the commit cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (LATENCY == 0) begin
                  w_commit    = 1'b1;
                  w_state_nxt = S_RESP;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_state_nxt = S_WAIT;
                  w_cnt_nxt   = LAT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_commit    = 1'b1;
               w_state_nxt = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (iRespReady) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // State and wait-counter registers.
   always_ff @(posedge iClk or negedge iRstN) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!iRstN) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Latch the request on accept so later input changes cannot affect it.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_req <= '0;
      end else if (w_accept) begin
         r_req <= w_req_in;
      end
   end

   // Response registers: captured at commit, zero for stores and errors.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_commit) begin
         r_err   <= w_err;
         r_rdata <= (w_err || w_req_cur.write) ? 32'd0 : w_load;
      end
   end

   // Storage array: byte-lane writes at commit of an error-free store.
   always_ff @(posedge iClk) begin
      // NOTE: the array has no reset branch; contents must survive reset and a
      // reset on a RAM would also block mapping it onto memory macros.
      if (w_commit && w_req_cur.write && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
            end
         end
      end
   end

   assign oReqReady  = (r_state == S_IDLE);
   assign oRespValid = (r_state == S_RESP);
   assign oRespRData = (r_state == S_RESP) ? r_rdata : 32'd0;
   assign oRespErr   = (r_state == S_RESP) && r_err;

endmodule
